// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package instr_fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] IF_BASE = 32'hBFC00000;

    // One prefetched instruction: the byte offset it came from and the word itself.
    typedef struct packed {
        logic [31:0]        offset;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; the head entry is visible combinationally.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a byte offset through instruction memory and
// buffers the returned words in a small prefetch queue for the consumer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                  A_length  = 12,
    parameter int                  DEPTH     = 4,
    parameter logic [A_length-1:0] RESET_OFF = A_length'(12'h000),
    parameter logic [31:0]         BASE      = IF_BASE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [A_length-1:0]      A,
    input  logic [INSTR_W-1:0]       RD,
    output logic [INSTR_W-1:0]       instr,
    output logic [31:0]              instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     fault,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [A_length-1:0] fpc;
    logic                push;
    logic                pop;
    logic                region_miss;
    logic                unused_pc_bits;
    fetch_entry_t        push_data;
    fetch_entry_t        head;

    // A redirect kills any handshake or fetch in its cycle.
    assign pop         = instr_valid && instr_ready && !redirect;
    assign push        = !redirect && ((count < DEPTH_C) || pop);
    assign region_miss = (redirect_pc[31:A_length] != BASE[31:A_length]);

    assign push_data   = '{offset: 32'(fpc), word: RD};

    // Offset advances by a word and wraps at the top of the region by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc <= RESET_OFF;
        end else if (redirect) begin
            fpc <= {redirect_pc[A_length-1:2], 2'b00};
        end else if (push) begin
            fpc <= fpc + A_length'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (redirect && region_miss) begin
            fault <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    assign A              = fpc;
    assign instr          = head.word;
    assign instr_pc       = BASE + head.offset;
    assign instr_valid    = (count != '0);
    assign unused_pc_bits = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch;

    localparam logic [31:0] BASE_C = 32'hBFC00000;
    localparam int          QDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] A;
    logic [31:0] RD;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fault;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    logic [11:0] mfpc = 12'h000;
    logic        mfault = 1'b0;
    bit          popped;
    bit          room;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A           (A),
        .RD          (RD),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fault       (fault),
        .count       (count)
    );

    function automatic logic [7:0] byteAt(input int i);
        return 8'(i * 3 + 1);
    endfunction

    // Big-endian word made of the bytes at a..a+3.
    function automatic logic [31:0] memWord(input logic [11:0] a);
        int i;
        i = int'(a);
        return {byteAt(i), byteAt(i + 1), byteAt(i + 2), byteAt(i + 3)};
    endfunction

    assign RD = memWord(A);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic rdr, input logic [31:0] rpc);
        #1;
        instr_ready = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Reference model: the queue of instructions the consumer must see.
    always @(negedge rst_n) begin
        q.delete();
        mfpc   = 12'h000;
        mfault = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (redirect) begin
                q.delete();
                mfpc = {redirect_pc[11:2], 2'b00};
                if (redirect_pc[31:12] != BASE_C[31:12]) mfault = 1'b1;
            end else begin
                popped = (q.size() != 0) && instr_ready;
                room   = (q.size() < QDEPTH) || popped;
                if (popped) void'(q.pop_front());
                if (room) begin
                    q.push_back('{pc: BASE_C + 32'(mfpc), word: memWord(mfpc)});
                    mfpc = mfpc + 12'd4;
                end
            end
        end
    end

    initial begin
        #12;
        forever begin
            @(negedge clk);
            checkOutput("model valid", 32'(instr_valid), 32'(q.size() != 0));
            checkOutput("model count", 32'(count), 32'(q.size()));
            checkOutput("model A", 32'(A), 32'(mfpc));
            checkOutput("model fault", 32'(fault), 32'(mfault));
            if (q.size() != 0) begin
                checkOutput("model instr_pc", instr_pc, q[0].pc);
                checkOutput("model instr", instr, q[0].word);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset A", 32'(A), 32'h0);
        checkOutput("reset valid", 32'(instr_valid), 32'h0);
        checkOutput("reset count", 32'(count), 32'h0);
        #2 rst_n = 1'b1;

        // Streaming straight out of reset.
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stream pc0", instr_pc, 32'hBFC00000);
        checkOutput("stream word0", instr, 32'h0104070A);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stream pc1", instr_pc, 32'hBFC00004);
        checkOutput("stream word1", instr, 32'h0D101316);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stream pc2", instr_pc, 32'hBFC00008);

        // Consumer stalls from reset: queue fills and fetch freezes.
        instr_ready = 1'b0;
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("stall count", 32'(count), 32'd4);
        checkOutput("stall A", 32'(A), 32'h010);
        checkOutput("stall head", instr_pc, 32'hBFC00000);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("resume pc", instr_pc, BASE_C + 32'(4 * i));
        end

        // Redirect while full, unaligned target.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("full count", 32'(count), 32'd4);
        applyStimulus(1'b1, 1'b1, 32'hBFC00105);
        checkOutput("redir count", 32'(count), 32'd0);
        checkOutput("redir valid", 32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redir pc", instr_pc, 32'hBFC00104);
        checkOutput("redir fault", 32'(fault), 32'd0);

        // Wrap at the top of the region.
        applyStimulus(1'b1, 1'b1, 32'hBFC00FF8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap pc0", instr_pc, 32'hBFC00FF8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap pc1", instr_pc, 32'hBFC00FFC);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap pc2", instr_pc, 32'hBFC00000);

        // Out-of-region target sets a sticky fault.
        applyStimulus(1'b1, 1'b1, 32'h80000000);
        checkOutput("fault rise", 32'(fault), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("fault pc0", instr_pc, 32'hBFC00000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("fault pc1", instr_pc, 32'hBFC00004);
        applyStimulus(1'b1, 1'b1, 32'hBFC00000);
        checkOutput("fault sticky", 32'(fault), 32'd1);

        // Asynchronous reset mid-cycle with three entries queued.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("pre-reset count", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async valid", 32'(instr_valid), 32'd0);
        checkOutput("async count", 32'(count), 32'd0);
        checkOutput("async A", 32'(A), 32'h0);
        checkOutput("async fault", 32'(fault), 32'd0);
        @(negedge clk);
        instr_ready = 1'b1;
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("restart pc", instr_pc, 32'hBFC00000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("restart pc1", instr_pc, 32'hBFC00004);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter A_length, default 12, meaning instruction-memory byte-address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, at least 2).
REQ-003 The block SHALL have parameter RESET_OFF, default 12'h000, meaning fetch byte offset after reset.
REQ-004 The block SHALL have parameter BASE, default 32'hBFC00000, meaning instruction region base address.
REQ-005 Ports SHALL be:
  - clk  in  1  clock; one clock, all state on the rising edge
  - rst_n  in  1  reset, asynchronous, active-low
  - A  out  A_length  byte offset driven to instruction memory
  - RD  in  32  instruction word returned combinationally, same cycle, for A
  - instr  out  32  head-of-queue instruction
  - instr_pc  out  32  full address of instr (BASE + offset)
  - instr_valid  out  1  queue head valid
  - instr_ready  in  1  consumer accepts head
  - redirect  in  1  flush and restart fetch
  - redirect_pc  in  32  new fetch address
  - fault  out  1  sticky: redirect target outside instruction region
  - count  out  $clog2(DEPTH)+1  current queue occupancy

Function
REQ-006 The block SHALL hold a fetch offset register fpc of width A_length; A SHALL equal fpc, with bits [1:0] always 0.
REQ-007 Push: when count < DEPTH, or a pop occurs in the same cycle, and redirect is low, the block SHALL enqueue {fpc, RD} and advance fpc by 4.
REQ-008 fpc SHALL wrap from 2**A_length-4 to 0 with no other effect.
REQ-009 Pop: a handshake SHALL occur when instr_valid and instr_ready are both high; the head entry is removed at that edge.
REQ-010 instr_valid SHALL equal (count != 0); instr and instr_pc SHALL be driven from the head entry, and SHALL hold stable while instr_valid is high and instr_ready is low.
REQ-011 Simultaneous push and pop at full SHALL leave count unchanged; simultaneous push and pop at empty SHALL NOT bypass: the pushed word appears on the next cycle.
REQ-012 Redirect SHALL take priority over push and pop in that cycle: queue emptied (count becomes 0), no handshake counted, fpc <= redirect_pc[A_length-1:2] concatenated with 2'b00.
REQ-013 redirect_pc[1:0] SHALL be ignored.
REQ-014 If redirect_pc[31:A_length] differs from BASE[31:A_length], fault SHALL be set and remain set until reset; fpc SHALL still load the low bits.
REQ-015 Steady-state latency SHALL be one cycle from fpc presentation to instr_valid; throughput SHALL be one instruction per cycle while instr_ready is held high.

Reset
REQ-016 While rst_n is low, and asynchronously on its falling edge, the block SHALL set fpc = RESET_OFF, count = 0, queue pointers = 0, and fault = 0.
REQ-017 During reset, outputs SHALL be A = RESET_OFF, instr_valid = 0, and count = 0; instr and instr_pc are don't-care while instr_valid = 0.
REQ-018 The first push SHALL occur on the first rising clk edge after rst_n deasserts; reset mid-stream SHALL discard all queued entries.

Structure
REQ-019 The shared package SHALL hold the BASE address constant, the instruction width (32), and the queue-entry struct type (offset, word).
REQ-020 The block SHALL contain one sub-module, fetch_fifo: a synchronous DEPTH-entry FIFO with push, pop, flush, count, and head outputs. The PC logic, fault logic, and address composition SHALL reside in instr_fetch.

Verification
REQ-021 Reset release with instr_ready = 1: instr_pc sequence SHALL be BFC00000, BFC00004, BFC00008, and instr SHALL match memory bytes [A..A+3] (big-endian), one per cycle.
REQ-022 instr_ready = 0 for 10 cycles: count SHALL saturate at 4, A SHALL freeze at 0x010, and the head SHALL stay BFC00000; on raising instr_ready, output SHALL resume in order with no gap or duplicate.
REQ-023 Redirect to BFC00105 while the queue is full and instr_ready = 1: the next cycle SHALL show count = 0 and instr_valid = 0; the cycle after SHALL present instr_pc = BFC00104; fault SHALL remain 0.
REQ-024 Redirect to BFC00FF8, continuous ready: instr_pc SHALL be BFC00FF8, BFC00FFC, then BFC00000 (wrap).
REQ-025 Redirect to 80000000: fault SHALL rise and stay high; fetch SHALL continue from offset 0x000.
REQ-026 Assert rst_n low asynchronously, mid-cycle, with the queue holding 3 entries: instr_valid SHALL drop immediately and count SHALL read 0 before the next clk edge.
